// File: rtl/peripheral_mpram_pkg.sv
// Shared types and helpers for the banked multi-port AHB3 RAM.
package peripheral_mpram_pkg;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  typedef enum logic [2:0] {
    P_IDLE,
    P_WAIT,
    P_RESP,
    P_ERR1,
    P_ERR2
  } port_state_e;

  // Wide enough for the largest bus (1024 bits = 128 byte lanes).
  localparam int BE_MAX = 128;

  // Full lane mask for the transfer size, shifted to the in-word byte offset.
  function automatic logic [BE_MAX-1:0] gen_be(input logic [2:0] size, input logic [6:0] offset);
    logic [BE_MAX-1:0] lanes;
    if (size == 3'd7) lanes = '1;
    else              lanes = (BE_MAX'(1) << (8'd1 << size)) - BE_MAX'(1);
    return lanes << offset;
  endfunction

endpackage

// File: rtl/peripheral_mpram_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer just past the granted requester.
module peripheral_mpram_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;

  function automatic int wrap(input int v);
    return (v >= N) ? v - N : v;
  endfunction

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_i[PW'(wrap(int'(ptr_q) + k))]) begin
        found = 1'b1;
        gnt_o[PW'(wrap(int'(ptr_q) + k))] = 1'b1;
        ptr_d = PW'(wrap(int'(ptr_q) + k + 1));
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/peripheral_mpram_ahb3_banked.sv
// Shared multi-port AHB-Lite SRAM, word-interleaved over single-port banks.
// Optional PERIPHERAL_MPRAM_OOR_ERROR_EN: ERROR response for addresses >= MEM_SIZE.
module peripheral_mpram_ahb3_banked
  import peripheral_mpram_pkg::*;
#(
  parameter int MEM_SIZE       = 4096,
  parameter int PLEN           = 32,
  parameter int XLEN           = 32,
  parameter int CORES_PER_TILE = 4,
  parameter int NUM_BANKS      = 4,
  parameter     TECHNOLOGY     = "GENERIC"
) (
  input  logic                                 HRESETn,
  input  logic                                 HCLK,
  input  logic [CORES_PER_TILE-1:0]            HSEL,
  input  logic [CORES_PER_TILE-1:0][PLEN-1:0]  HADDR,
  input  logic [CORES_PER_TILE-1:0][XLEN-1:0]  HWDATA,
  output logic [CORES_PER_TILE-1:0][XLEN-1:0]  HRDATA,
  input  logic [CORES_PER_TILE-1:0]            HWRITE,
  input  logic [CORES_PER_TILE-1:0][2:0]       HSIZE,
  input  logic [CORES_PER_TILE-1:0][2:0]       HBURST,
  input  logic [CORES_PER_TILE-1:0][3:0]       HPROT,
  input  logic [CORES_PER_TILE-1:0][1:0]       HTRANS,
  input  logic [CORES_PER_TILE-1:0]            HMASTLOCK,
  input  logic [CORES_PER_TILE-1:0]            HREADY,
  output logic [CORES_PER_TILE-1:0]            HREADYOUT,
  output logic [CORES_PER_TILE-1:0]            HRESP
);

  localparam int BYTES     = XLEN / 8;
  localparam int OFF_BITS  = $clog2(BYTES);
  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int BW        = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int DEPTH     = 8 * MEM_SIZE / XLEN / NUM_BANKS;
  localparam int RW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                      port_wait  [CORES_PER_TILE];
  logic                      port_write [CORES_PER_TILE];
  logic [BW-1:0]             port_bank  [CORES_PER_TILE];
  logic [RW-1:0]             port_row   [CORES_PER_TILE];
  logic [BYTES-1:0]          port_be    [CORES_PER_TILE];
  logic [CORES_PER_TILE-1:0] bank_gnt   [NUM_BANKS];
  logic [XLEN-1:0]           bank_dout  [NUM_BANKS];
  logic [CORES_PER_TILE-1:0] served;

  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HADDR, TECHNOLOGY == "GENERIC"};

  always_comb begin
    served = '0;
    for (int b = 0; b < NUM_BANKS; b++) served = served | bank_gnt[b];
  end

  genvar gi, gb;

  for (gi = 0; gi < CORES_PER_TILE; gi++) begin : g_port
    port_state_e      state_q, state_d;
    logic [BW-1:0]    bank_q;
    logic [RW-1:0]    row_q;
    logic [BYTES-1:0] be_q;
    logic             write_q;
    logic             ready, capture, oor;

    assign ready   = (state_q != P_WAIT) && (state_q != P_ERR1);
    assign capture = HSEL[gi] & HREADY[gi] & ready &
                     ((HTRANS[gi] == HTRANS_NONSEQ) || (HTRANS[gi] == HTRANS_SEQ));

`ifdef PERIPHERAL_MPRAM_OOR_ERROR_EN
    assign oor = (HADDR[gi] >= PLEN'(MEM_SIZE));
`else
    assign oor = 1'b0;
`endif

    always_comb begin
      state_d = state_q;
      case (state_q)
        P_IDLE, P_RESP, P_ERR2: state_d = capture ? (oor ? P_ERR1 : P_WAIT) : P_IDLE;
        P_WAIT:                 if (served[gi]) state_d = P_RESP;
        P_ERR1:                 state_d = P_ERR2;
        default:                state_d = P_IDLE;
      endcase
    end

    // Bank/row come from the word index; bits above the row wrap modulo MEM_SIZE.
    always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
        state_q <= P_IDLE;
        bank_q  <= '0;
        row_q   <= '0;
        be_q    <= '0;
        write_q <= 1'b0;
      end else begin
        state_q <= state_d;
        if (capture) begin
          bank_q  <= BW'((HADDR[gi] >> OFF_BITS) & PLEN'(NUM_BANKS - 1));
          row_q   <= RW'(HADDR[gi] >> (OFF_BITS + BANK_BITS));
          be_q    <= BYTES'(gen_be(HSIZE[gi], 7'(HADDR[gi] & PLEN'(BYTES - 1))));
          write_q <= HWRITE[gi];
        end
      end
    end

    assign HREADYOUT[gi]  = ready;
    assign HRESP[gi]      = (state_q == P_ERR1 || state_q == P_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA[gi]     = (state_q == P_RESP && !write_q) ? bank_dout[bank_q] : '0;
    assign port_wait[gi]  = (state_q == P_WAIT);
    assign port_write[gi] = write_q;
    assign port_bank[gi]  = bank_q;
    assign port_row[gi]   = row_q;
    assign port_be[gi]    = be_q;
  end

  for (gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
    logic [CORES_PER_TILE-1:0] req, gnt;
    logic                      en, we;
    logic [RW-1:0]             row;
    logic [BYTES-1:0]          be;
    logic [XLEN-1:0]           wd;
    logic [XLEN-1:0]           dout_q;
    logic [XLEN-1:0]           mem [DEPTH];

    for (gi = 0; gi < CORES_PER_TILE; gi++) begin : g_req
      assign req[gi] = port_wait[gi] && (port_bank[gi] == BW'(gb));
    end

    peripheral_mpram_rr_arbiter #(
      .N (CORES_PER_TILE)
    ) u_arb (
      .clk_i  (HCLK),
      .rst_ni (HRESETn),
      .req_i  (req),
      .gnt_o  (gnt)
    );

    // HWDATA is safe to use here: the granted port is still stalling its master.
    always_comb begin
      en = 1'b0;
      we = 1'b0;
      row = '0;
      be = '0;
      wd = '0;
      for (int p = 0; p < CORES_PER_TILE; p++) begin
        if (gnt[p]) begin
          en  = 1'b1;
          we  = port_write[p];
          row = port_row[p];
          be  = port_be[p];
          wd  = HWDATA[p];
        end
      end
    end

    always_ff @(posedge HCLK) begin
      if (en) begin
        if (we) begin
          for (int i = 0; i < BYTES; i++) begin
            if (be[i]) mem[row][i*8 +: 8] <= wd[i*8 +: 8];
          end
        end else begin
          dout_q <= mem[row];
        end
      end
    end

    assign bank_gnt[gb]  = gnt;
    assign bank_dout[gb] = dout_q;
  end

endmodule

// File: tb/tb_peripheral_mpram_ahb3_banked.sv
// Self-checking bench for the banked multi-port AHB3 RAM (default 4 ports x 4 banks, 32-bit).
module tb_peripheral_mpram_ahb3_banked;

  localparam int N        = 4;
  localparam int MEM_SIZE = 4096;

  logic                HCLK = 1'b0;
  logic                HRESETn = 1'b0;
  logic [N-1:0]        HSEL, HWRITE, HMASTLOCK, HREADY, HREADYOUT, HRESP;
  logic [N-1:0][31:0]  HADDR, HWDATA, HRDATA;
  logic [N-1:0][2:0]   HSIZE, HBURST;
  logic [N-1:0][3:0]   HPROT;
  logic [N-1:0][1:0]   HTRANS;

  always #5 HCLK = ~HCLK;

  peripheral_mpram_ahb3_banked dut (
    .HRESETn   (HRESETn),
    .HCLK      (HCLK),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HPROT     (HPROT),
    .HTRANS    (HTRANS),
    .HMASTLOCK (HMASTLOCK),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP)
  );

  typedef struct {
    int          tag;
    int          port;
    int          waits;
    logic [31:0] rdata;
    logic        resp;
  } exp_t;

  typedef struct {
    int          port;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[16];
  int   errors = 0;
  int   checks = 0;

  int          g_tag   [N];
  logic        g_wr    [N];
  logic [31:0] g_addr  [N];
  logic [2:0]  g_size  [N];
  logic [31:0] g_wdata [N];
  int          g_waits [N];
  logic [31:0] g_rdata [N];

  task automatic check_val(input string name, input int tag, input logic [31:0] act,
                           input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s tag=%0d actual=%h expected=%h", name, tag, act, exp);
    end
  endtask

  task automatic idle_bus();
    HSEL   = '0;
    HTRANS = '0;
  endtask

  task automatic set_slot(input int p, input int tag, input logic wr, input logic [31:0] addr,
                          input logic [2:0] size, input logic [31:0] wdata, input int waits,
                          input logic [31:0] rdata);
    g_tag[p] = tag; g_wr[p] = wr; g_addr[p] = addr; g_size[p] = size;
    g_wdata[p] = wdata; g_waits[p] = waits; g_rdata[p] = rdata;
  endtask

  task automatic complete(input int p, input int waits);
    int   idx;
    exp_t e;
    idx = -1;
    foreach (sb[i]) if (idx < 0 && sb[i].port == p) idx = i;
    if (idx < 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected port=%0d actual=response expected=none", p);
    end else begin
      e = sb[idx];
      sb.delete(idx);
      $display("txn tag=%0d port=%0d waits=%0d rdata=%h resp=%0d", e.tag, p, waits, HRDATA[p], HRESP[p]);
      check_val("waits", e.tag, 32'(waits), 32'(e.waits));
      check_val("rdata", e.tag, HRDATA[p], e.rdata);
      check_val("resp", e.tag, {31'b0, HRESP[p]}, {31'b0, e.resp});
    end
  endtask

  // Issue one transfer on every port in mask in the same cycle, then follow each to completion.
  task automatic run_group(input logic [N-1:0] mask);
    int           waits [N];
    logic [N-1:0] done;
    int           cyc;
    for (int p = 0; p < N; p++) begin
      waits[p] = 0;
      if (mask[p]) begin
        HSEL[p] = 1'b1; HTRANS[p] = 2'b10; HADDR[p] = g_addr[p];
        HWRITE[p] = g_wr[p]; HSIZE[p] = g_size[p];
        sb.push_back('{g_tag[p], p, g_waits[p], g_wr[p] ? 32'h0 : g_rdata[p], 1'b0});
      end
    end
    @(posedge HCLK); #1;
    idle_bus();
    for (int p = 0; p < N; p++) if (mask[p]) HWDATA[p] = g_wdata[p];
    done = ~mask;
    cyc  = 0;
    while (done != '1 && cyc < 20) begin
      @(negedge HCLK);
      for (int p = 0; p < N; p++) begin
        if (!done[p]) begin
          if (HREADYOUT[p]) begin
            done[p] = 1'b1;
            complete(p, waits[p]);
          end else begin
            waits[p]++;
          end
        end
      end
      cyc++;
    end
    for (int p = 0; p < N; p++) begin
      if (!done[p]) begin
        checks++;
        errors++;
        $display("FAIL timeout port=%0d actual=no_hreadyout expected=hreadyout", p);
      end
    end
    @(posedge HCLK); #1;
  endtask

  initial begin
    HSEL = '0; HWRITE = '0; HMASTLOCK = '0; HREADY = '1; HADDR = '0; HWDATA = '0;
    HSIZE = '0; HBURST = '0; HPROT = '0; HTRANS = '0;

    repeat (3) @(posedge HCLK);
    #1;
    check_val("rst_hreadyout", -1, 32'(HREADYOUT), 32'hF);
    check_val("rst_hresp", -1, 32'(HRESP), 32'h0);
    check_val("rst_hrdata", -1, HRDATA[0] | HRDATA[1] | HRDATA[2] | HRDATA[3], 32'h0);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // port, write, addr, size, wdata, expected read data
    vecs[0]  = '{0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{0, 1'b0, 32'h10, 3'd2, 32'h0, 32'hDEADBEEF};
    vecs[2]  = '{1, 1'b1, 32'h10, 3'd2, 32'h11223344, 32'h0};
    vecs[3]  = '{1, 1'b1, 32'h13, 3'd0, 32'hAA000000, 32'h0};
    vecs[4]  = '{2, 1'b0, 32'h10, 3'd2, 32'h0, 32'hAA223344};
    vecs[5]  = '{3, 1'b1, 32'h00, 3'd2, 32'h01010101, 32'h0};
    vecs[6]  = '{3, 1'b1, 32'h02, 3'd1, 32'hCAFE0000, 32'h0};
    vecs[7]  = '{0, 1'b0, 32'h00, 3'd2, 32'h0, 32'hCAFE0101};
    vecs[8]  = '{1, 1'b1, 32'h20, 3'd2, 32'h20202020, 32'h0};
    vecs[9]  = '{2, 1'b1, 32'h30, 3'd2, 32'h30303030, 32'h0};
    vecs[10] = '{3, 1'b1, 32'h04, 3'd2, 32'h44444444, 32'h0};
    vecs[11] = '{0, 1'b1, 32'h08, 3'd2, 32'h88888888, 32'h0};
    vecs[12] = '{1, 1'b1, 32'h0C, 3'd2, 32'hCCCCCCCC, 32'h0};
    vecs[13] = '{0, 1'b1, 32'h24, 3'd2, 32'h12345678, 32'h0};
    vecs[14] = '{3, 1'b0, 32'h04, 3'd2, 32'h0, 32'h44444444};
    vecs[15] = '{1, 1'b0, 32'h13, 3'd0, 32'h0, 32'hAA223344};
    for (int v = 0; v < 16; v++) begin
      set_slot(vecs[v].port, v, vecs[v].wr, vecs[v].addr, vecs[v].size, vecs[v].wdata, 1,
               vecs[v].rdata);
      run_group(4'(1 << vecs[v].port));
    end

    // BUSY with HSEL, then NONSEQ without HSEL: neither may start a transfer.
    for (int c = 0; c < 2; c++) begin
      HSEL[0] = (c == 0); HTRANS[0] = (c == 0) ? 2'b01 : 2'b10;
      HADDR[0] = 32'h10; HWRITE[0] = 1'b0;
      @(posedge HCLK); #1;
      idle_bus();
      @(negedge HCLK);
      check_val("noxfer_ready", 100 + c, 32'(HREADYOUT[0]), 32'h1);
      check_val("noxfer_rdata", 100 + c, HRDATA[0], 32'h0);
      check_val("noxfer_resp", 100 + c, 32'(HRESP[0]), 32'h0);
      @(posedge HCLK); #1;
    end

    // Reset clears the arbiter pointers but keeps RAM contents.
    HRESETn = 1'b0;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Two rounds of four ports on bank 0: 1..4 wait states, rotation back to port 0.
    for (int r = 0; r < 2; r++) begin
      set_slot(0, 20 + 10*r, 1'b0, 32'h00, 3'd2, 32'h0, 1, 32'hCAFE0101);
      set_slot(1, 21 + 10*r, 1'b0, 32'h10, 3'd2, 32'h0, 2, 32'hAA223344);
      set_slot(2, 22 + 10*r, 1'b0, 32'h20, 3'd2, 32'h0, 3, 32'h20202020);
      set_slot(3, 23 + 10*r, 1'b0, 32'h30, 3'd2, 32'h0, 4, 32'h30303030);
      run_group(4'hF);
    end

    // Four ports on four different banks proceed in parallel.
    set_slot(0, 40, 1'b0, 32'h00, 3'd2, 32'h0, 1, 32'hCAFE0101);
    set_slot(1, 41, 1'b0, 32'h04, 3'd2, 32'h0, 1, 32'h44444444);
    set_slot(2, 42, 1'b0, 32'h08, 3'd2, 32'h0, 1, 32'h88888888);
    set_slot(3, 43, 1'b0, 32'h0C, 3'd2, 32'h0, 1, 32'hCCCCCCCC);
    run_group(4'hF);

    // Port 1 writes 0x20 (grant G), port 2 reads 0x20 (grant G+1).
    HSEL[1] = 1'b1; HTRANS[1] = 2'b10; HADDR[1] = 32'h20; HWRITE[1] = 1'b1; HSIZE[1] = 3'd2;
    @(posedge HCLK); #1;
    HSEL[1] = 1'b0; HTRANS[1] = 2'b00; HWDATA[1] = 32'h5;
    HSEL[2] = 1'b1; HTRANS[2] = 2'b10; HADDR[2] = 32'h20; HWRITE[2] = 1'b0; HSIZE[2] = 3'd2;
    @(negedge HCLK);
    check_val("raw_p1_wait", 50, 32'(HREADYOUT[1]), 32'h0);
    @(posedge HCLK); #1;
    idle_bus();
    @(negedge HCLK);
    check_val("raw_p1_done", 50, 32'(HREADYOUT[1]), 32'h1);
    check_val("raw_p2_wait", 51, 32'(HREADYOUT[2]), 32'h0);
    @(negedge HCLK);
    check_val("raw_p2_done", 51, 32'(HREADYOUT[2]), 32'h1);
    check_val("raw_p2_rdata", 51, HRDATA[2], 32'h5);
    $display("txn tag=51 port=2 raw read rdata=%h", HRDATA[2]);
    @(posedge HCLK); #1;

    // Reset while port 3 waits: ready returns at once and the write is dropped.
    HSEL[3] = 1'b1; HTRANS[3] = 2'b10; HADDR[3] = 32'h24; HWRITE[3] = 1'b1; HSIZE[3] = 3'd2;
    @(posedge HCLK); #1;
    idle_bus();
    HWDATA[3] = 32'hFFFFFFFF;
    #2;
    check_val("rstw_wait", 55, 32'(HREADYOUT[3]), 32'h0);
    HRESETn = 1'b0;
    #1;
    check_val("rstw_ready", 55, 32'(HREADYOUT[3]), 32'h1);
    check_val("rstw_resp", 55, 32'(HRESP[3]), 32'h0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    set_slot(0, 56, 1'b0, 32'h24, 3'd2, 32'h0, 1, 32'h12345678);
    run_group(4'b0001);

`ifdef PERIPHERAL_MPRAM_OOR_ERROR_EN
    HSEL[2] = 1'b1; HTRANS[2] = 2'b10; HADDR[2] = MEM_SIZE; HWRITE[2] = 1'b0; HSIZE[2] = 3'd2;
    @(posedge HCLK); #1;
    idle_bus();
    @(negedge HCLK);
    check_val("oor_err1_ready", 60, 32'(HREADYOUT[2]), 32'h0);
    check_val("oor_err1_resp", 60, 32'(HRESP[2]), 32'h1);
    @(negedge HCLK);
    check_val("oor_err2_ready", 60, 32'(HREADYOUT[2]), 32'h1);
    check_val("oor_err2_resp", 60, 32'(HRESP[2]), 32'h1);
    @(negedge HCLK);
    check_val("oor_idle_resp", 60, 32'(HRESP[2]), 32'h0);
    $display("txn tag=60 port=2 out-of-range read");
    @(posedge HCLK); #1;
`else
    set_slot(2, 60, 1'b0, MEM_SIZE, 3'd2, 32'h0, 1, 32'hCAFE0101);
    run_group(4'b0100);
`endif

    check_val("sb_drained", -1, 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
